// File: rtl/mips_16_wb_trace.sv
// mips_16_wb_trace
//   Captures WB-stage register writes from the MIPS-16 core into a small
//   FIFO of trace records that a consumer drains with a valid/ready handshake.
//   Record layout: {timestamp[34:19], dest[18:16], data[15:0]}.
//
// Configuration macro:
//   MIPS16_TRACE_TIMESTAMP_EN - when defined, a 16-bit free-running cycle
//                               counter stamps each record; when undefined
//                               the counter is omitted and bits [34:19] are 0.
//
// Ports:
//   clk            core clock
//   rst            synchronous active-high reset
//   trace_en       capture enable
//   reg_write_en   WB write strobe
//   reg_write_dest WB destination register (3 bits)
//   reg_write_data WB write data (16 bits)
//   trace_valid    head record available (registered)
//   trace_ready    consumer accepts head record
//   trace_data     head record (registered, 35 bits)
//   trace_count    FIFO occupancy, 0..DEPTH
//   overflow       sticky: at least one record dropped
//   drop_count     dropped-record count, saturates at 0xFF
//   clear_ovf      clears overflow and drop_count (a same-cycle drop wins)
module mips_16_wb_trace #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    input  logic                     reg_write_en,
    input  logic [2:0]               reg_write_dest,
    input  logic [15:0]              reg_write_data,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [34:0]              trace_data,
    output logic [$clog2(DEPTH):0]   trace_count,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    input  logic                     clear_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [34:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [15:0]   ts_now;

`ifdef MIPS16_TRACE_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) ts_cnt <= '0;
        else     ts_cnt <= ts_cnt + 16'd1;
    end

    assign ts_now = ts_cnt;
`else
    assign ts_now = '0;
`endif

    logic          push_req;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [34:0]   rec;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count_next;
    logic [34:0]   head_next;

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        push_req   = trace_en & reg_write_en;
        full       = (trace_count == FULL_CNT);
        pop        = trace_valid & trace_ready;
        // A full FIFO still accepts a capture when the head leaves this cycle.
        push       = push_req & (~full | pop);
        drop       = push_req & full & ~pop;
        rec        = {ts_now, reg_write_dest, reg_write_data};
        rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
        count_next = trace_count;
        case ({push, pop})
            2'b10:   count_next = trace_count + 1'b1;
            2'b01:   count_next = trace_count - 1'b1;
            default: count_next = trace_count;
        endcase
        // The next head is either already in memory or is the record being
        // written this very edge (empty FIFO, or single entry replaced).
        head_next = '0;
        if (count_next != '0) begin
            if (push && (wr_ptr == rd_next)) head_next = rec;
            else                             head_next = mem[rd_next];
        end
    end

    // NOTE: the storage array is not reset; occupancy and pointers alone
    // decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= rec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            trace_count <= '0;
            trace_valid <= 1'b0;
            trace_data  <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr      <= rd_next;
            trace_count <= count_next;
            trace_valid <= (count_next != '0);
            trace_data  <= head_next;
            if (drop) begin
                overflow   <= 1'b1;
                // A drop coinciding with a clear restarts the count at one.
                if (clear_ovf)                drop_count <= 8'd1;
                else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end else if (clear_ovf) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mips_16_wb_trace.sv
// Self-checking bench for mips_16_wb_trace: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_mips_16_wb_trace;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trace_en = 1'b0;
    logic          reg_write_en = 1'b0;
    logic [2:0]    reg_write_dest = '0;
    logic [15:0]   reg_write_data = '0;
    logic          trace_ready = 1'b0;
    logic          clear_ovf = 1'b0;
    logic          trace_valid;
    logic [34:0]   trace_data;
    logic [CW-1:0] trace_count;
    logic          overflow;
    logic [7:0]    drop_count;

    mips_16_wb_trace #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .trace_en       (trace_en),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_data     (trace_data),
        .trace_count    (trace_count),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_ovf      (clear_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [34:0] q[$];
    int unsigned cyc = 0;
    bit          m_ovf = 1'b0;
    int          m_dc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ts_of(input int unsigned c);
`ifdef MIPS16_TRACE_TIMESTAMP_EN
        return c[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    // Advance the model by one edge using the current inputs, clock the DUT,
    // then compare all outputs.
    task automatic step();
        bit full_b, do_pop, cap, dropped;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_dc  = 0;
            cyc   = 0;
        end else begin
            full_b  = (q.size() == DEPTH);
            do_pop  = (q.size() != 0) && trace_ready;
            cap     = trace_en && reg_write_en;
            dropped = cap && full_b && !do_pop;
            if (do_pop) void'(q.pop_front());
            if (cap && !dropped) q.push_back({ts_of(cyc), reg_write_dest, reg_write_data});
            if (dropped) begin
                m_ovf = 1'b1;
                m_dc  = clear_ovf ? 1 : ((m_dc == 255) ? 255 : m_dc + 1);
            end else if (clear_ovf) begin
                m_ovf = 1'b0;
                m_dc  = 0;
            end
            cyc = (cyc + 1) % 65536;
        end
        @(posedge clk);
        #1;
        check("valid", trace_valid, q.size() != 0);
        check("count", trace_count, q.size());
        if (q.size() != 0) check("data", trace_data, q[0]);
        check("overflow", overflow, m_ovf);
        check("drop_count", drop_count, m_dc);
    endtask

    task automatic drive(input bit cap, input logic [2:0] d, input logic [15:0] v,
                         input bit rdy, input bit clr);
        trace_en       = cap;
        reg_write_en   = cap;
        reg_write_dest = d;
        reg_write_data = v;
        trace_ready    = rdy;
        clear_ovf      = clr;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    logic [34:0] exp31;
    logic [15:0] ts5;

    initial begin
        // Reset state
        do_reset();
        drive(1'b1, 3'd1, 16'hDEAD, 1'b0, 1'b0);  // ignored while rst held? no: rst now low
        do_reset();
        check("rst_data", trace_data, 35'h0);
        check("rst_valid", trace_valid, 1'b0);
        check("rst_count", trace_count, 0);

        // Write r3=0x1234 at cycle 5 after reset
        for (int i = 0; i < 5; i++) drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        drive(1'b1, 3'd3, 16'h1234, 1'b0, 1'b0);
`ifdef MIPS16_TRACE_TIMESTAMP_EN
        ts5 = 16'h0005;
`else
        ts5 = 16'h0000;
`endif
        exp31 = {ts5, 3'd3, 16'h1234};
        check("r3_valid", trace_valid, 1'b1);
        check("r3_data", trace_data, exp31);
        drive(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        check("r3_drained", trace_valid, 1'b0);

        // Write to r0 is captured; ready while empty is harmless
        drive(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        drive(1'b1, 3'd0, 16'h0F0F, 1'b1, 1'b0);
        check("r0_count", trace_count, 1);
        drive(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);

        // 10 back-to-back writes into DEPTH=8 with no draining
        do_reset();
        for (int i = 0; i < 10; i++) drive(1'b1, 3'(i), 16'hA000 + 16'(i), 1'b0, 1'b0);
        check("ovf10_count", trace_count, 8);
        check("ovf10_flag", overflow, 1'b1);
        check("ovf10_drops", drop_count, 8'd2);
        for (int i = 0; i < 8; i++) begin
            check("drain_order", trace_data[15:0], 16'hA000 + 16'(i));
            drive(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        end
        check("drain_empty", trace_valid, 1'b0);

        // Full FIFO: capture with simultaneous pop is accepted
        for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 16'hB000 + 16'(i), 1'b0, 1'b0);
        drive(1'b1, 3'd5, 16'hB0B0, 1'b1, 1'b0);
        check("fullpop_count", trace_count, 8);
        check("fullpop_drops", drop_count, 8'd2);

        // Clear coinciding with a drop: drop wins, count restarts at 1
        drive(1'b1, 3'd6, 16'hC0C0, 1'b0, 1'b1);
        check("clrdrop_flag", overflow, 1'b1);
        check("clrdrop_drops", drop_count, 8'd1);

        // 300 drops saturate the counter; clear resets it
        for (int i = 0; i < 300; i++) drive(1'b1, 3'd7, 16'(i), 1'b0, 1'b0);
        check("sat_drops", drop_count, 8'hFF);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
        check("clr_drops", drop_count, 8'h00);
        check("clr_flag", overflow, 1'b0);

        // trace_en low stops capture but draining continues
        trace_en = 1'b0;
        reg_write_en = 1'b1;
        trace_ready = 1'b1;
        clear_ovf = 1'b0;
        step();
        check("en_off_count", trace_count, 7);

        // Reset with 5 records held
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 3'(i), 16'hD000 + 16'(i), 1'b0, 1'b0);
        check("held5", trace_count, 5);
        rst = 1'b1;
        drive(1'b1, 3'd2, 16'hEEEE, 1'b1, 1'b0);
        check("rst5_valid", trace_valid, 1'b0);
        check("rst5_count", trace_count, 0);
        rst = 1'b0;

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 599) == 0);
            drive($urandom_range(0, 3) != 0, 3'($urandom), 16'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
            if (n % 1000 == 500) begin
                // stretch of heavy backpressure to force fills and drops
                for (int k = 0; k < 20; k++) begin
                    rst = 1'b0;
                    drive(1'b1, 3'($urandom), 16'($urandom), 1'b0, 1'b0);
                end
            end
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
